// File: rtl/div_ctrl.sv
// div_ctrl: multi-cycle radix-2 restoring divider sequencer for MIPS DIV/DIVU.
// Produces {remainder (HI), quotient (LO)} one quotient bit per cycle.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start_i             divide request, held by EX until ready_o is consumed
//   annul_i             flush/cancel, overrides start_i
//   signed_div_i        1 = DIV (two's complement), 0 = DIVU
//   dividend_i          rs operand, sampled when start is accepted
//   divisor_i           rt operand, sampled when start is accepted
//   result_o            {remainder, quotient}, valid while ready_o = 1
//   ready_o             result valid
//   stall_req_o         pipeline freeze request while the divide is pending
//
// Optional build macro:
//   DIV_EARLY_ZERO_EN   a zero dividend (nonzero divisor) short-cuts through
//                       the DIVBYZERO path for a 2-edge latency.
module div_ctrl #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    annul_i,
    input  logic                    signed_div_i,
    input  logic [DATA_WIDTH-1:0]   dividend_i,
    input  logic [DATA_WIDTH-1:0]   divisor_i,
    output logic [2*DATA_WIDTH-1:0] result_o,
    output logic                    ready_o,
    output logic                    stall_req_o
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);

    localparam logic [1:0] FREE      = 2'd0;
    localparam logic [1:0] DIVBYZERO = 2'd1;
    localparam logic [1:0] ON        = 2'd2;
    localparam logic [1:0] END       = 2'd3;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] dvs;
    logic                  sign_a;
    logic                  sign_b;
    logic                  is_signed;

    logic                  a_neg;
    logic                  b_neg;
    logic [DATA_WIDTH-1:0] a_mag;
    logic [DATA_WIDTH-1:0] b_mag;
    logic                  zero_path;
    logic [DATA_WIDTH:0]   shifted;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] q_fix;
    logic [DATA_WIDTH-1:0] r_fix;

    assign stall_req_o = start_i & ~ready_o & ~annul_i;

    // Signed operands are divided as magnitudes; signs are reapplied at the end.
    assign a_neg = signed_div_i & dividend_i[DATA_WIDTH-1];
    assign b_neg = signed_div_i & divisor_i[DATA_WIDTH-1];
    assign a_mag = a_neg ? ('0 - dividend_i) : dividend_i;
    assign b_mag = b_neg ? ('0 - divisor_i) : divisor_i;

`ifdef DIV_EARLY_ZERO_EN
    assign zero_path = (divisor_i == '0) | (dividend_i == '0);
`else
    assign zero_path = (divisor_i == '0);
`endif

    // One restoring step: bring the next dividend bit into the partial
    // remainder and try to subtract the divisor; the borrow bit decides.
    assign shifted = {rem, quo[DATA_WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};

    assign q_fix = (is_signed & (sign_a ^ sign_b)) ? ('0 - quo) : quo;
    assign r_fix = (is_signed & sign_a) ? ('0 - rem) : rem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FREE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_signed <= 1'b0;
            result_o  <= '0;
            ready_o   <= 1'b0;
        end else if (annul_i) begin
            state    <= FREE;
            cnt      <= '0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            unique case (state)
                FREE: begin
                    if (start_i) begin
                        rem       <= '0;
                        quo       <= a_mag;
                        dvs       <= b_mag;
                        sign_a    <= a_neg;
                        sign_b    <= b_neg;
                        is_signed <= signed_div_i;
                        cnt       <= '0;
                        state     <= zero_path ? DIVBYZERO : ON;
                    end
                end
                DIVBYZERO: begin
                    result_o <= '0;
                    ready_o  <= 1'b1;
                    state    <= END;
                end
                ON: begin
                    if (cnt != LAST) begin
                        if (!diff[DATA_WIDTH]) begin
                            rem <= diff[DATA_WIDTH-1:0];
                            quo <= {quo[DATA_WIDTH-2:0], 1'b1};
                        end else begin
                            rem <= shifted[DATA_WIDTH-1:0];
                            quo <= {quo[DATA_WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                    end else begin
                        result_o <= {r_fix, q_fix};
                        ready_o  <= 1'b1;
                        state    <= END;
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        state    <= FREE;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: self-checking bench for div_ctrl.
// Table vectors, hand-written corner sequences and randomized ops vs a model.
module tb_div_ctrl;

    localparam int W = 32;
`ifdef DIV_EARLY_ZERO_EN
    localparam int ZL = 2;
`else
    localparam int ZL = 34;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          annul = 1'b0;
    logic          sdiv = 1'b0;
    logic [W-1:0]  dvd = '0;
    logic [W-1:0]  dvs = '0;
    logic [2*W-1:0] result;
    logic          ready;
    logic          stall;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    div_ctrl #(.DATA_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start_i(start), .annul_i(annul),
        .signed_div_i(sdiv), .dividend_i(dvd), .divisor_i(dvs),
        .result_o(result), .ready_o(ready), .stall_req_o(stall)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] res;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Division by magnitudes in wide integers, signs applied afterwards.
    function automatic logic [63:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic s);
        longint am, bm, q, r;
        logic na, nb;
        if (b == 0) return 64'h0;
        na = s && a[31];
        nb = s && b[31];
        am = na ? -(longint'($signed(a))) : longint'(a);
        bm = nb ? -(longint'($signed(b))) : longint'(b);
        q = am / bm;
        r = am % bm;
        if (na ^ nb) q = -q;
        if (na) r = -r;
        return {r[31:0], q[31:0]};
    endfunction

    // Edge E (acceptance) counts as latency 1.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           input logic s,
                           output logic [63:0] res, output int lat,
                           output logic busy_stall, output logic done_stall,
                           output logic [63:0] held_res, output logic held_rdy,
                           output logic aft_rdy, output logic [63:0] aft_res);
        @(negedge clk);
        start = 1'b1; sdiv = s; dvd = a; dvs = b;
        @(posedge clk); #1;
        busy_stall = stall;
        dvd = $urandom; dvs = $urandom; sdiv = 1'($urandom_range(0, 1));
        lat = 1;
        while (!ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        done_stall = stall;
        @(posedge clk); #1;
        held_res = result;
        held_rdy = ready;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        aft_rdy = ready;
        aft_res = result;
    endtask

    task automatic no_ready(input string name, input int n);
        logic seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        check(name, 64'(seen), 64'h0);
    endtask

    vec_t vecs[$];
    logic [63:0] res, hres, ares;
    logic bst, dst, hrdy, ardy;
    int lat;

    initial begin
        vecs.push_back('{32'hFFFFFFFF, 32'h00000010, 1'b0, 64'h0000000F_0FFFFFFF, 34});
        vecs.push_back('{32'hFFFFFFF9, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFD, 34});
        vecs.push_back('{32'h00000007, 32'hFFFFFFFE, 1'b1, 64'h00000001_FFFFFFFD, 34});
        vecs.push_back('{32'h00001234, 32'h00000000, 1'b0, 64'h0, 2});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 34});
        vecs.push_back('{32'h00000000, 32'h00000005, 1'b0, 64'h0, ZL});
        vecs.push_back('{32'h00000064, 32'h00000007, 1'b0, 64'h00000002_0000000E, 34});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 64'h80000000_00000000, 34});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b1, 64'h00000000_FFFFFFFF, 34});

        #12;
        check("reset_ready", 64'(ready), 64'h0);
        check("reset_result", result, 64'h0);
        check("reset_stall", 64'(stall), 64'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].s,
                    res, lat, bst, dst, hres, hrdy, ardy, ares);
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("vec%0d_res", i), res, vecs[i].res);
            check($sformatf("vec%0d_busy_stall", i), 64'(bst), 64'h1);
            check($sformatf("vec%0d_done_stall", i), 64'(dst), 64'h0);
            check($sformatf("vec%0d_hold_res", i), hres, vecs[i].res);
            check($sformatf("vec%0d_hold_rdy", i), 64'(hrdy), 64'h1);
            check($sformatf("vec%0d_free_rdy", i), 64'(ardy), 64'h0);
            check($sformatf("vec%0d_free_res", i), ares, 64'h0);
        end

        // annul at cnt = 10
        @(negedge clk);
        start = 1'b1; sdiv = 1'b0; dvd = 32'd100; dvs = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        #1 check("annul_stall", 64'(stall), 64'h0);
        @(posedge clk); #1;
        check("annul_ready", 64'(ready), 64'h0);
        check("annul_result", result, 64'h0);
        @(negedge clk);
        annul = 1'b0; start = 1'b0;
        no_ready("annul_no_result", 40);
        run_div(32'd100, 32'd7, 1'b0, res, lat, bst, dst, hres, hrdy, ardy, ares);
        check("post_annul_res", res, 64'h00000002_0000000E);
        check("post_annul_lat", 64'(lat), 64'd34);

        // annul and start together in FREE: not accepted
        @(negedge clk);
        start = 1'b1; annul = 1'b1; dvd = 32'd9; dvs = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        check("annul_start_ready", 64'(ready), 64'h0);
        check("annul_start_stall", 64'(stall), 64'h0);
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        no_ready("annul_start_no_accept", 40);

        // reset at cnt = 20
        @(negedge clk);
        start = 1'b1; sdiv = 1'b0; dvd = 32'd1000; dvs = 32'd3;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ready", 64'(ready), 64'h0);
        check("rst_mid_result", result, 64'h0);
        check("rst_mid_stall", 64'(stall), 64'h0);
        @(negedge clk);
        rst = 1'b0;
        no_ready("rst_mid_free", 40);
        run_div(32'd1000, 32'd3, 1'b0, res, lat, bst, dst, hres, hrdy, ardy, ares);
        check("post_rst_res", res, 64'h00000001_0000014D);

        // randomized ops vs model
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            logic s;
            int elat;
            a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
            if (i % 6 == 0) b = 32'h0;
            if (i % 6 == 1) a = 32'h0;
            if (i % 6 == 2) b = 32'($urandom_range(1, 300));
            if (i % 6 == 3) b = 32'hFFFFFFFF - 32'($urandom_range(0, 9));
            elat = (b == 0) ? 2 : ((a == 0) ? ZL : 34);
            run_div(a, b, s, res, lat, bst, dst, hres, hrdy, ardy, ares);
            check($sformatf("rnd%0d_res a=%h b=%h s=%0d", i, a, b, s),
                  res, model(a, b, s));
            check($sformatf("rnd%0d_lat", i), 64'(lat), 64'(elat));
            check($sformatf("rnd%0d_free_rdy", i), 64'(ardy), 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Multi-cycle iterative divider sequencer for MIPS DIV/DIVU; sits beside EX and writes the HI/LO pair.
- EX holds start_i while the op is in EX; the block runs a radix-2 restoring division, one quotient bit per cycle.
- Holds stall_req_o until the result is ready; the pipeline control unit freezes IF..EX while it is high.
- Returns {remainder, quotient} for HI/LO writeback.

Parameters:
- DATA_WIDTH, 32, operand width; cycle count and counter width are derived from it.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  divide request; held high by EX until it has consumed ready_o.
- annul_i  in  1  cancel request (branch/exception flush); overrides start_i.
- signed_div_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
- dividend_i  in  DATA_WIDTH  rs value; sampled when start is accepted.
- divisor_i  in  DATA_WIDTH  rt value; sampled when start is accepted.
- result_o  out  2*DATA_WIDTH  {remainder (HI), quotient (LO)}; valid only while ready_o=1.
- ready_o  out  1  result valid.
- stall_req_o  out  1  pipeline stall request; combinational, = start_i & ~ready_o & ~annul_i.

Behaviour:
- Reset (async, rst=1): state=FREE; cnt=0; result_o=0; ready_o=0; internal dividend/divisor registers cleared.
- States: FREE, DIVBYZERO, ON, END.
- FREE, when start_i=1 and annul_i=0 (accepted at edge E):
  - divisor_i==0 -> DIVBYZERO.
  - otherwise -> ON with cnt=0.
  - Operands latched at edge E. If signed_div_i=1, each negative operand is latched as its two's-complement magnitude. The two signs and signed_div_i are latched separately.
- ON, per cycle with cnt<DATA_WIDTH:
  - Shift {partial remainder, dividend} left one bit; trial-subtract the divisor.
  - If the trial result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the remainder and shift in 0.
  - cnt increments.
- ON, cnt==DATA_WIDTH:
  - Signed sign fix: quotient negated if dividend sign XOR divisor sign; remainder negated if dividend sign.
  - Register result_o; ready_o=1; -> END.
  - ready_o is first high after the 34th rising edge following edge E (DATA_WIDTH=32).
- DIVBYZERO: one cycle; result_o=0; ready_o=1; -> END. ready_o is high after the 2nd edge following E.
- END: result_o and ready_o hold while start_i=1. When start_i=0: -> FREE, ready_o=0, result_o=0.
- annul_i=1 in any state: -> FREE at the next edge; ready_o=0; result_o=0; cnt=0; no result is produced.
  - annul_i and start_i both high in FREE: the request is not accepted.
- start_i dropping in ON or DIVBYZERO without annul_i: no effect; the operation completes, passes through END, then returns to FREE.
- Operand inputs are ignored after acceptance; changing them mid-operation has no effect.
- Signed overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (wraps, no trap).
- Reset asserted mid-operation aborts immediately to the reset values.

Optional Feature:
- Macro: DIV_EARLY_ZERO_EN.
- Defined: an accepted start with dividend_i==0 (and divisor nonzero) takes the DIVBYZERO path. Result 0, ready_o after 2 edges instead of 34.
- Undefined: a zero dividend runs the full ON sequence; same result value (0), 34-edge latency.

Test Plan:
- Unsigned 0xFFFFFFFF / 0x00000010, start held -> ready_o rises after 34th edge; result_o=0x0000000F_0FFFFFFF; stall_req_o low once ready_o is high.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also 7 / -2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (dividend 0x1234) -> ready_o after 2nd edge, result_o=0. Then drop start_i -> FREE next edge, ready_o=0.
- Start 100/7, assert annul_i at cnt=10 -> FREE next edge, ready_o never rises. A fresh start of 100/7 then yields 0x00000002_0000000E.
- Assert rst mid-ON (cnt=20) -> all outputs 0 immediately (async); state FREE after release.
- Dividend 0 / 5 -> result 0; latency 2 edges with DIV_EARLY_ZERO_EN defined, 34 edges without.
